// File: rtl/lab_subtraction_serial.sv
// lab_subtraction_serial
//   Bit-serial subtractor for the board lab. On a rising edge of start the
//   switch operands are captured and difference = minuend - subtrahend is
//   produced LSB-first, one bit per clock, through a single full-subtractor
//   cell and a borrow flip-flop. The result and the final borrow are shown
//   on LEDs, together with busy/done indicators.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   minuend        switch operand A, sampled only at the capture edge
//   subtrahend     switch operand B, sampled only at the capture edge
//   start          debounced pushbutton level; a rising edge starts an operation
//   minuend_led    live echo of the minuend switches
//   subtrahend_led live echo of the subtrahend switches
//   diff_led       registered (A - B) mod 2^WIDTH
//   borrow_led     registered final borrow (A < B, unsigned)
//   busy_led       high while bits are being shifted
//   done_led       high once a result is available, until the next start
module lab_subtraction_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             start,
  output logic [WIDTH-1:0] minuend_led,
  output logic [WIDTH-1:0] subtrahend_led,
  output logic [WIDTH-1:0] diff_led,
  output logic             borrow_led,
  output logic             busy_led,
  output logic             done_led
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic             start_q;
  logic             start_pulse;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] d_next;

  function automatic logic fs_diff(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

  // Switch echoes are purely combinational so they follow the switches even in reset.
  assign minuend_led    = minuend;
  assign subtrahend_led = subtrahend;

  assign start_pulse = start & ~start_q;

  always_comb begin
    d_bit   = fs_diff(a_sh[0], b_sh[0], br);
    br_next = fs_borrow(a_sh[0], b_sh[0], br);
    // New bit enters at the MSB; after WIDTH shifts the first bit sits at bit 0.
    d_next  = {d_bit, d_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      a_sh       <= '0;
      b_sh       <= '0;
      d_sh       <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff_led   <= '0;
      borrow_led <= 1'b0;
      busy_led   <= 1'b0;
      done_led   <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        IDLE, DONE: begin
          if (start_pulse) begin
            a_sh     <= minuend;
            b_sh     <= subtrahend;
            d_sh     <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            busy_led <= 1'b1;
            done_led <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // start pulses are deliberately ignored here: no restart, no queuing.
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_next;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            diff_led   <= d_next;
            borrow_led <= br_next;
            busy_led   <= 1'b0;
            done_led   <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          busy_led <= 1'b0;
          done_led <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lab_subtraction_serial.md
Name: lab_subtraction_serial

Overview:
- Bit-serial subtractor for the board lab flow. It computes difference = minuend - subtrahend from slide switches.
- Processing is LSB-first, one bit per clock, using a single full-subtractor cell and a borrow flip-flop.
- Result and final borrow are shown on LEDs, with busy/done indicators.
- It is the inverse-operation counterpart of the combinational switch-to-LED adder lab, and reuses that block's switch-echo LED convention.

Parameters:
- WIDTH, 4, operand and difference width in bits; legal range 2..16.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- minuend  input  WIDTH  switch operand A; sampled only at the capture edge.
- subtrahend  input  WIDTH  switch operand B; sampled only at the capture edge.
- start  input  1  pushbutton, level; already synchronised and debounced upstream; rising edge triggers.
- minuend_led  output  WIDTH  live echo of the minuend switches.
- subtrahend_led  output  WIDTH  live echo of the subtrahend switches.
- diff_led  output  WIDTH  registered difference (A-B) mod 2^WIDTH.
- borrow_led  output  1  registered final borrow; 1 when A < B unsigned.
- busy_led  output  1  high while in SHIFT.
- done_led  output  1  high while in DONE.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0 the block is forced to IDLE and clears:
  - start_q, operand shift registers, borrow FF, counter, diff_led, borrow_led, busy_led, done_led all =0.
  - minuend_led and subtrahend_led are combinational echoes and are not affected by reset.
- Edge detect:
  - start_q <= start on every clock.
  - start_pulse = start & ~start_q (combinational).
  - Holding start high produces exactly one pulse.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: busy=0, done=0. On start_pulse:
    - load a_sh<=minuend, b_sh<=subtrahend, br<=0, cnt<=0, d_sh<=0;
    - go to SHIFT.
  - SHIFT: busy=1. Each edge:
    - d = a0 ^ b0 ^ br;
    - br <= (~a0 & b0) | (~(a0 ^ b0) & br);
    - a_sh and b_sh shift right; d enters d_sh at the MSB and d_sh shifts right;
    - cnt <= cnt+1.
  - SHIFT exit: on the edge where cnt==WIDTH-1, the final bit and borrow are computed. diff_led <= completed d_sh value including this bit, borrow_led <= new borrow, then go to DONE.
  - SHIFT duration: exactly WIDTH cycles.
  - DONE: done=1, busy=0. diff_led and borrow_led hold. On start_pulse, perform the same load as IDLE and go to SHIFT. done_led falls on that same edge.
- Latency:
  - Capture edge = edge k, where start=1 and start_q=0.
  - diff_led, borrow_led and done_led are updated at edge k+WIDTH.
- diff_led and borrow_led keep the previous result throughout SHIFT. They change only on the SHIFT->DONE edge or on reset.
- Switch changes after the capture edge have no effect on the in-flight result; only the *_led echoes follow them.
- start_pulse during SHIFT is ignored: no restart and no queuing. start_q still tracks, so releasing and re-pressing after DONE retriggers.
- Arithmetic:
  - The result equals (minuend - subtrahend) mod 2^WIDTH.
  - borrow_led = (minuend < subtrahend), unsigned compare.
  - No signed interpretation.
- cnt width: clog2(WIDTH). It never wraps within an operation.
- Reset asserted mid-SHIFT aborts immediately: outputs return to reset values and there is no partial result.
- busy_led and done_led are never both high; both are low only in IDLE.

Test Plan:
1. WIDTH=4, A=9, B=3, start pulse → busy 4 cycles; at capture+4: diff_led=6, borrow_led=0, done_led=1.
2. A=3, B=9 → diff_led=4'hA, borrow_led=1 (underflow wrap).
3. Boundary operands:
   - A=0, B=0 → diff=0, borrow=0.
   - A=15, B=15 → diff=0, borrow=0.
   - A=0, B=1 → diff=15, borrow=1.
   - A=15, B=0 → diff=15, borrow=0.
4. Start held high 20 cycles with A=7, B=2 → exactly one operation, diff=5. A new press from DONE with A=2, B=7 → diff=11, borrow=1, and done drops on the capture edge.
5. Mid-operation interference:
   - Change switches to A=1, B=1 two cycles after capture of 12-5 → result is still 7.
   - A second start pulse during SHIFT is ignored; done is asserted at capture+4 only.
6. Assert rst_n=0 asynchronously at capture+2 → all registered outputs 0 immediately; after release the state is IDLE, and no done appears without a new start.
